// File: rtl/param_shift_reg.sv
// Parameterised serial-in, parallel-out shift register: bit 0 takes data_in, bits move toward the MSB.
// Optional fill-tracking data_valid output is enabled by defining PARAM_SHIFT_REG_VALID_EN.
module param_shift_reg #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             data_in,
   output logic [WIDTH-1:0] data_out
`ifdef PARAM_SHIFT_REG_VALID_EN
   ,
   output logic             data_valid
`endif
);

   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] shift_d;

   generate
      if (WIDTH == 1) begin : g_single
         // Single-stage case: the register simply samples data_in.
         always_comb begin
            shift_d = data_in;
         end
      end else begin : g_multi
         // Shift left by one, new bit into the LSB, MSB discarded.
         always_comb begin
            shift_d = {shift_q[WIDTH-2:0], data_in};
         end
      end
   endgenerate

   // Shift register state, cleared asynchronously to RESET_VALUE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= RESET_VALUE;
      end else begin
         shift_q <= shift_d;
      end
   end

   assign data_out = shift_q;

`ifdef PARAM_SHIFT_REG_VALID_EN
   localparam int             CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  FULL = CW'(WIDTH);

   logic [CW-1:0] fill_q;
   logic [CW-1:0] fill_d;
   logic          valid_q;
   logic          valid_d;

   // Saturating fill count; valid once every stage holds a post-reset bit.
   always_comb begin
      if (fill_q == FULL) begin
         fill_d = fill_q;
      end else begin
         fill_d = fill_q + CW'(1);
      end
      valid_d = (fill_d == FULL);
   end

   // Fill counter and registered valid flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_q  <= {CW{1'b0}};
         valid_q <= 1'b0;
      end else begin
         fill_q  <= fill_d;
         valid_q <= valid_d;
      end
   end

   assign data_valid = valid_q;
`endif

endmodule

// File: tb/tb_param_shift_reg.sv
// Directed bench for param_shift_reg: WIDTH=8 and WIDTH=1 instances, optional data_valid checks.
module tb_param_shift_reg;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rst1_n;
   logic       data_in;
   logic       din1;
   logic [7:0] data_out;
   logic [0:0] out1;
`ifdef PARAM_SHIFT_REG_VALID_EN
   logic       data_valid;
   logic       valid1;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   param_shift_reg #(.WIDTH(8)) dut8 (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_in  (data_in),
      .data_out (data_out)
`ifdef PARAM_SHIFT_REG_VALID_EN
      ,
      .data_valid (data_valid)
`endif
   );

   param_shift_reg #(.WIDTH(1)) dut1 (
      .clk      (clk),
      .rst_n    (rst1_n),
      .data_in  (din1),
      .data_out (out1)
`ifdef PARAM_SHIFT_REG_VALID_EN
      ,
      .data_valid (valid1)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Called just after a falling edge: drive, clock once, return at the next falling edge.
   task automatic step8(input logic b);
      data_in = b;
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [7:0] exp_two [10] = '{8'h01, 8'h03, 8'h06, 8'h0C, 8'h18,
                                8'h30, 8'h60, 8'hC0, 8'h80, 8'h00};
   logic       walk_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
   logic [7:0] walk_exp  [8] = '{8'h01, 8'h02, 8'h05, 8'h0B,
                                 8'h16, 8'h2C, 8'h59, 8'hB2};
   logic       w1_bits [3] = '{1'b1, 1'b0, 1'b1};

   initial begin
      rst_n   = 1'b0;
      rst1_n  = 1'b0;
      data_in = 1'b0;
      din1    = 1'b0;

      // Reset held across several edges
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset_hold", {24'h0, data_out}, 32'h00);
`ifdef PARAM_SHIFT_REG_VALID_EN
         chk("reset_valid", {31'h0, data_valid}, 32'h0);
`endif
      end

      // Two ones then zeros, released at a falling edge
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step8((i < 2) ? 1'b1 : 1'b0);
         chk("two_ones", {24'h0, data_out}, {24'h0, exp_two[i]});
`ifdef PARAM_SHIFT_REG_VALID_EN
         chk("fill_valid", {31'h0, data_valid}, (i >= 7) ? 32'h1 : 32'h0);
`endif
      end

      // Build C0 then clear asynchronously between edges
      step8(1'b1);
      step8(1'b1);
      for (int i = 0; i < 6; i++) step8(1'b0);
      chk("pre_reset_c0", {24'h0, data_out}, 32'hC0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_clear", {24'h0, data_out}, 32'h00);
`ifdef PARAM_SHIFT_REG_VALID_EN
      chk("async_valid", {31'h0, data_valid}, 32'h0);
`endif
      data_in = 1'b1;
      @(negedge clk);
      chk("clear_held1", {24'h0, data_out}, 32'h00);
      @(negedge clk);
      chk("clear_held2", {24'h0, data_out}, 32'h00);

      // Walking pattern from a fresh reset
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step8(walk_bits[i]);
         chk("walk", {24'h0, data_out}, {24'h0, walk_exp[i]});
      end

      // WIDTH=1 instance, reset released now
      chk("w1_reset", {31'h0, out1}, 32'h0);
`ifdef PARAM_SHIFT_REG_VALID_EN
      chk("w1_reset_valid", {31'h0, valid1}, 32'h0);
`endif
      rst1_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         din1 = w1_bits[i];
         #1;
         chk("w1_no_comb", {31'h0, out1}, (i == 0) ? 32'h0 : {31'h0, w1_bits[i-1]});
         @(posedge clk);
         @(negedge clk);
         chk("w1_follow", {31'h0, out1}, {31'h0, w1_bits[i]});
`ifdef PARAM_SHIFT_REG_VALID_EN
         chk("w1_valid", {31'h0, valid1}, 32'h1);
`endif
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
